// File: rtl/axi_mem_arbiter_if.sv
// One full AXI port set (AR, R, AW, W, B) shared by the CPU-side masters and the memory side.
// The "master" modport drives requests; the "slave" modport drives ready/response signals.
interface axi_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic [ADDR_W-1:0] ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [LEN_W-1:0]  AWLEN;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  modport master (
    output ARADDR, ARLEN, ARVALID, input ARREADY,
    input  RDATA, RLAST, RVALID, output RREADY,
    output AWADDR, AWLEN, AWVALID, input AWREADY,
    output WDATA, WLAST, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY
  );

  modport slave (
    input  ARADDR, ARLEN, ARVALID, output ARREADY,
    output RDATA, RLAST, RVALID, input RREADY,
    input  AWADDR, AWLEN, AWVALID, output AWREADY,
    input  WDATA, WLAST, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY
  );
endinterface

// File: rtl/axi_mem_arbiter.sv
// 2:1 AXI arbiter: instruction (I) and data (D) masters share one memory slave, one burst at a time.
// Define ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module axi_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                resetn,
  axi_mem_arbiter_if.slave    i_axi,
  axi_mem_arbiter_if.slave    d_axi,
  axi_mem_arbiter_if.master   m_axi,
  output logic [1:0]          grant,
  output logic                len_err
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP
  } state_e;

  state_e            state_q;
  logic [1:0]        grant_q;
  logic              len_err_q;
  logic [LEN_W:0]    beat_q;
  logic [LEN_W-1:0]  arlen_q;

  logic              req_i, req_d, win_d, sel_d;
  logic [ADDR_W-1:0] g_araddr, g_awaddr;
  logic [LEN_W-1:0]  g_arlen, g_awlen;
  logic [DATA_W-1:0] g_wdata;
  logic              g_arvalid, g_rready, g_awvalid, g_wvalid, g_wlast, g_bready;
  logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign req_i = i_axi.ARVALID | i_axi.AWVALID;
  assign req_d = d_axi.ARVALID | d_axi.AWVALID;

`ifdef ARB_RR_EN
  // Set when D won the most recent conflict; only contested cycles move the pointer.
  logic rr_d_last_q;
  assign win_d = req_d & (~req_i | ~rr_d_last_q);
`else
  assign win_d = req_d;
`endif

  assign sel_d     = grant_q[1];
  assign g_araddr  = sel_d ? d_axi.ARADDR  : i_axi.ARADDR;
  assign g_arlen   = sel_d ? d_axi.ARLEN   : i_axi.ARLEN;
  assign g_arvalid = sel_d ? d_axi.ARVALID : i_axi.ARVALID;
  assign g_rready  = sel_d ? d_axi.RREADY  : i_axi.RREADY;
  assign g_awaddr  = sel_d ? d_axi.AWADDR  : i_axi.AWADDR;
  assign g_awlen   = sel_d ? d_axi.AWLEN   : i_axi.AWLEN;
  assign g_awvalid = sel_d ? d_axi.AWVALID : i_axi.AWVALID;
  assign g_wdata   = sel_d ? d_axi.WDATA   : i_axi.WDATA;
  assign g_wlast   = sel_d ? d_axi.WLAST   : i_axi.WLAST;
  assign g_wvalid  = sel_d ? d_axi.WVALID  : i_axi.WVALID;
  assign g_bready  = sel_d ? d_axi.BREADY  : i_axi.BREADY;

  assign ar_hs = g_arvalid & m_axi.ARREADY;
  assign r_hs  = m_axi.RVALID & g_rready;
  assign aw_hs = g_awvalid & m_axi.AWREADY;
  assign w_hs  = g_wvalid & m_axi.WREADY;
  assign b_hs  = m_axi.BVALID & g_bready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      len_err_q <= 1'b0;
      beat_q    <= '0;
      arlen_q   <= '0;
`ifdef ARB_RR_EN
      rr_d_last_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_i | req_d) begin
            grant_q <= win_d ? 2'b10 : 2'b01;
            // Within a master a pending write goes first so stores commit before loads.
            state_q <= (win_d ? d_axi.AWVALID : i_axi.AWVALID) ? WR_ADDR : RD_ADDR;
`ifdef ARB_RR_EN
            if (req_i & req_d) rr_d_last_q <= win_d;
`endif
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            arlen_q <= g_arlen;
            beat_q  <= '0;
            state_q <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            if (beat_q != '1) beat_q <= beat_q + 1'b1;
            if (m_axi.RLAST) begin
              // beat_q still holds the beats before this last one, i.e. ARLEN when correct.
              if (beat_q != {1'b0, arlen_q}) len_err_q <= 1'b1;
              grant_q <= '0;
              state_q <= IDLE;
            end
          end
        end
        WR_ADDR: if (aw_hs) state_q <= WR_DATA;
        WR_DATA: if (w_hs && g_wlast) state_q <= WR_RESP;
        WR_RESP: begin
          if (b_hs) begin
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign len_err = len_err_q;

  always_comb begin
    m_axi.ARADDR  = '0;
    m_axi.ARLEN   = '0;
    m_axi.ARVALID = 1'b0;
    m_axi.RREADY  = 1'b0;
    m_axi.AWADDR  = '0;
    m_axi.AWLEN   = '0;
    m_axi.AWVALID = 1'b0;
    m_axi.WDATA   = '0;
    m_axi.WLAST   = 1'b0;
    m_axi.WVALID  = 1'b0;
    m_axi.BREADY  = 1'b0;
    i_axi.ARREADY = 1'b0;
    i_axi.RDATA   = '0;
    i_axi.RLAST   = 1'b0;
    i_axi.RVALID  = 1'b0;
    i_axi.AWREADY = 1'b0;
    i_axi.WREADY  = 1'b0;
    i_axi.BRESP   = '0;
    i_axi.BVALID  = 1'b0;
    d_axi.ARREADY = 1'b0;
    d_axi.RDATA   = '0;
    d_axi.RLAST   = 1'b0;
    d_axi.RVALID  = 1'b0;
    d_axi.AWREADY = 1'b0;
    d_axi.WREADY  = 1'b0;
    d_axi.BRESP   = '0;
    d_axi.BVALID  = 1'b0;
    unique case (state_q)
      RD_ADDR: begin
        m_axi.ARADDR  = g_araddr;
        m_axi.ARLEN   = g_arlen;
        m_axi.ARVALID = g_arvalid;
        if (sel_d) d_axi.ARREADY = m_axi.ARREADY;
        else       i_axi.ARREADY = m_axi.ARREADY;
      end
      RD_DATA: begin
        m_axi.RREADY = g_rready;
        if (sel_d) begin
          d_axi.RDATA  = m_axi.RDATA;
          d_axi.RLAST  = m_axi.RLAST;
          d_axi.RVALID = m_axi.RVALID;
        end else begin
          i_axi.RDATA  = m_axi.RDATA;
          i_axi.RLAST  = m_axi.RLAST;
          i_axi.RVALID = m_axi.RVALID;
        end
      end
      WR_ADDR: begin
        m_axi.AWADDR  = g_awaddr;
        m_axi.AWLEN   = g_awlen;
        m_axi.AWVALID = g_awvalid;
        if (sel_d) d_axi.AWREADY = m_axi.AWREADY;
        else       i_axi.AWREADY = m_axi.AWREADY;
      end
      WR_DATA: begin
        m_axi.WDATA  = g_wdata;
        m_axi.WLAST  = g_wlast;
        m_axi.WVALID = g_wvalid;
        if (sel_d) d_axi.WREADY = m_axi.WREADY;
        else       i_axi.WREADY = m_axi.WREADY;
      end
      WR_RESP: begin
        m_axi.BREADY = g_bready;
        if (sel_d) begin
          d_axi.BRESP  = m_axi.BRESP;
          d_axi.BVALID = m_axi.BVALID;
        end else begin
          i_axi.BRESP  = m_axi.BRESP;
          i_axi.BVALID = m_axi.BVALID;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: two master drivers, a small AXI memory slave, vector table
// plus hand-written contention, write-before-read, length-error and mid-burst reset sequences.
module tb_axi_mem_arbiter;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic resetn;
  logic [1:0] grant;
  logic len_err;
  always #5 clk = ~clk;

  axi_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) ia ();
  axi_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) da ();
  axi_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) ma ();

  axi_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
    .clk(clk), .resetn(resetn), .i_axi(ia), .d_axi(da), .m_axi(ma),
    .grant(grant), .len_err(len_err)
  );

  // Master-side drive, index 0 = I, 1 = D
  logic [31:0] araddr [2];
  logic [31:0] awaddr [2];
  logic [31:0] wdata  [2];
  logic [7:0]  arlen  [2];
  logic [7:0]  awlen  [2];
  logic [1:0]  arvalid, rready, awvalid, wvalid, wlast, bready;

  assign ia.ARADDR = araddr[0];  assign da.ARADDR = araddr[1];
  assign ia.ARLEN  = arlen[0];   assign da.ARLEN  = arlen[1];
  assign ia.ARVALID = arvalid[0]; assign da.ARVALID = arvalid[1];
  assign ia.RREADY = rready[0];  assign da.RREADY = rready[1];
  assign ia.AWADDR = awaddr[0];  assign da.AWADDR = awaddr[1];
  assign ia.AWLEN  = awlen[0];   assign da.AWLEN  = awlen[1];
  assign ia.AWVALID = awvalid[0]; assign da.AWVALID = awvalid[1];
  assign ia.WDATA  = wdata[0];   assign da.WDATA  = wdata[1];
  assign ia.WLAST  = wlast[0];   assign da.WLAST  = wlast[1];
  assign ia.WVALID = wvalid[0];  assign da.WVALID = wvalid[1];
  assign ia.BREADY = bready[0];  assign da.BREADY = bready[1];

  logic [1:0]  arready_s, rvalid_s, rlast_s, awready_s, wready_s, bvalid_s, mst_out;
  logic [31:0] rdata_s [2];
  logic [1:0]  bresp_s [2];
  logic        any_out;
  assign arready_s = {da.ARREADY, ia.ARREADY};
  assign rvalid_s  = {da.RVALID, ia.RVALID};
  assign rlast_s   = {da.RLAST, ia.RLAST};
  assign awready_s = {da.AWREADY, ia.AWREADY};
  assign wready_s  = {da.WREADY, ia.WREADY};
  assign bvalid_s  = {da.BVALID, ia.BVALID};
  assign rdata_s[0] = ia.RDATA;  assign rdata_s[1] = da.RDATA;
  assign bresp_s[0] = ia.BRESP;  assign bresp_s[1] = da.BRESP;
  assign mst_out[0] = |{ia.ARREADY, ia.RDATA, ia.RLAST, ia.RVALID, ia.AWREADY, ia.WREADY,
                        ia.BRESP, ia.BVALID};
  assign mst_out[1] = |{da.ARREADY, da.RDATA, da.RLAST, da.RVALID, da.AWREADY, da.WREADY,
                        da.BRESP, da.BVALID};
  assign any_out = |{mst_out, ma.ARADDR, ma.ARLEN, ma.ARVALID, ma.RREADY, ma.AWADDR, ma.AWLEN,
                     ma.AWVALID, ma.WDATA, ma.WLAST, ma.WVALID, ma.BREADY};

  // Memory slave: word-addressed, mem[k] = 0xA0000000+k after reset; optional early RLAST.
  typedef enum logic [1:0] {S_IDLE, S_R, S_W, S_B} sst_e;
  sst_e        s_st;
  logic [7:0]  s_idx, s_beat, s_len;
  logic [31:0] mem [256];
  logic        short_last;

  assign ma.ARREADY = (s_st == S_IDLE);
  assign ma.AWREADY = (s_st == S_IDLE);
  assign ma.RVALID  = (s_st == S_R);
  assign ma.RDATA   = (s_st == S_R) ? mem[8'(s_idx + s_beat)] : 32'h0;
  assign ma.RLAST   = (s_st == S_R) && ((s_beat == s_len) || (short_last && s_beat == 8'd2));
  assign ma.WREADY  = (s_st == S_W);
  assign ma.BVALID  = (s_st == S_B);
  assign ma.BRESP   = 2'b00;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_st <= S_IDLE; s_idx <= '0; s_beat <= '0; s_len <= '0;
      for (int k = 0; k < 256; k++) mem[k] <= 32'hA000_0000 + 32'(k);
    end else begin
      case (s_st)
        S_IDLE: if (ma.ARVALID) begin
                  s_st <= S_R; s_idx <= ma.ARADDR[9:2]; s_len <= ma.ARLEN; s_beat <= '0;
                end else if (ma.AWVALID) begin
                  s_st <= S_W; s_idx <= ma.AWADDR[9:2]; s_beat <= '0;
                end
        S_R: if (ma.RREADY) begin
               if (ma.RLAST) s_st <= S_IDLE;
               else s_beat <= s_beat + 8'd1;
             end
        S_W: if (ma.WVALID) begin
               mem[8'(s_idx + s_beat)] <= ma.WDATA;
               s_beat <= s_beat + 8'd1;
               if (ma.WLAST) s_st <= S_B;
             end
        S_B: if (ma.BREADY) s_st <= S_IDLE;
        default: s_st <= S_IDLE;
      endcase
    end
  end

  int checks = 0;
  int failures = 0;
  int order[$];
  logic [31:0] rbuf [2][16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_rd(input int m, input logic [31:0] addr, input logic [7:0] len,
                       output int lat, output logic [31:0] maddr, output logic early,
                       output int nb);
    int cyc, iso;
    logic done;
    logic [1:0] gexp;
    gexp = (m == 1) ? 2'b10 : 2'b01;
    lat = 0; nb = 0; iso = 0; done = 1'b0; maddr = '0;
    @(negedge clk);
    araddr[m] = addr; arlen[m] = len; arvalid[m] = 1'b1;
    #1 early = ma.ARVALID;
    cyc = 0;
    while (cyc == 0 || (!arready_s[m] && cyc < TMO)) begin
      @(negedge clk); cyc++;
    end
    lat = cyc; maddr = ma.ARADDR;
    chk($sformatf("rd%0d_ar_handshake", m), 64'(arready_s[m]), 64'd1);
    if (arready_s[m]) order.push_back(m);
    @(negedge clk);
    arvalid[m] = 1'b0; rready[m] = 1'b1;
    cyc = 0;
    while (!done && cyc < TMO) begin
      if (rvalid_s[m]) begin
        if (nb < 16) rbuf[m][nb] = rdata_s[m];
        nb++;
        if (rlast_s[m]) done = 1'b1;
        if (mst_out[1-m] || grant != gexp) iso++;
      end
      @(negedge clk); cyc++;
    end
    rready[m] = 1'b0;
    chk($sformatf("rd%0d_rlast_seen", m), 64'(done), 64'd1);
    chk($sformatf("rd%0d_isolation", m), 64'(iso), 64'd0);
  endtask

  task automatic do_wr(input int m, input logic [31:0] addr, input logic [7:0] len,
                       input logic [31:0] d0, output int lat, output logic [31:0] maddr,
                       output logic early, output logic [1:0] bresp);
    int cyc, iso;
    logic [1:0] gexp;
    gexp = (m == 1) ? 2'b10 : 2'b01;
    iso = 0; maddr = '0; bresp = 2'b11;
    @(negedge clk);
    awaddr[m] = addr; awlen[m] = len; awvalid[m] = 1'b1;
    #1 early = ma.AWVALID;
    cyc = 0;
    while (cyc == 0 || (!awready_s[m] && cyc < TMO)) begin
      @(negedge clk); cyc++;
    end
    lat = cyc; maddr = ma.AWADDR;
    chk($sformatf("wr%0d_aw_handshake", m), 64'(awready_s[m]), 64'd1);
    if (awready_s[m]) order.push_back(m + 2);
    @(negedge clk);
    awvalid[m] = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      wdata[m] = d0 + 32'(k); wlast[m] = (k == int'(len)); wvalid[m] = 1'b1;
      cyc = 0;
      while (!wready_s[m] && cyc < TMO) begin
        @(negedge clk); cyc++;
      end
      if (mst_out[1-m] || grant != gexp) iso++;
      @(negedge clk);
    end
    wvalid[m] = 1'b0; wlast[m] = 1'b0;
    bready[m] = 1'b1;
    cyc = 0;
    while (!bvalid_s[m] && cyc < TMO) begin
      @(negedge clk); cyc++;
    end
    chk($sformatf("wr%0d_bvalid_seen", m), 64'(bvalid_s[m]), 64'd1);
    bresp = bresp_s[m];
    if (mst_out[1-m] || grant != gexp) iso++;
    @(negedge clk);
    bready[m] = 1'b0;
    chk($sformatf("wr%0d_isolation", m), 64'(iso), 64'd0);
  endtask

  typedef struct {
    int          m;
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] d0;   // write data of beat 0, or expected read data of beat 0 (beat k = d0+k)
  } vec_t;

  vec_t vec [6];
  int lat, nb, lat2, nb2;
  logic [31:0] maddr, maddr2;
  logic early, early2;
  logic [1:0] bresp;
  int cyc;

  initial begin
    vec[0] = '{0, 1'b0, 32'h100, 8'd3, 32'hA000_0040};
    vec[1] = '{1, 1'b1, 32'h040, 8'd0, 32'hDEAD_BEEF};
    vec[2] = '{1, 1'b0, 32'h040, 8'd0, 32'hDEAD_BEEF};
    vec[3] = '{0, 1'b1, 32'h010, 8'd1, 32'h1111_0000};
    vec[4] = '{0, 1'b0, 32'h010, 8'd1, 32'h1111_0000};
    vec[5] = '{1, 1'b0, 32'h304, 8'd2, 32'hA000_00C1};

    resetn = 1'b0; short_last = 1'b0;
    arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; wlast = '0; bready = '0;
    for (int i = 0; i < 2; i++) begin
      araddr[i] = '0; awaddr[i] = '0; wdata[i] = '0; arlen[i] = '0; awlen[i] = '0;
    end

    repeat (10) @(negedge clk);
    chk("reset_outputs", 64'(any_out), 64'd0);
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_len_err", 64'(len_err), 64'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_outputs", 64'(any_out), 64'd0);
    chk("idle_grant", 64'(grant), 64'd0);

    for (int i = 0; i < 6; i++) begin
      if (!vec[i].wr) begin
        do_rd(vec[i].m, vec[i].addr, vec[i].len, lat, maddr, early, nb);
        chk($sformatf("vec%0d_beats", i), 64'(nb), 64'(vec[i].len) + 64'd1);
        for (int k = 0; k <= int'(vec[i].len); k++)
          chk($sformatf("vec%0d_rdata%0d", i, k), 64'(rbuf[vec[i].m][k]), 64'(vec[i].d0 + 32'(k)));
      end else begin
        do_wr(vec[i].m, vec[i].addr, vec[i].len, vec[i].d0, lat, maddr, early, bresp);
        chk($sformatf("vec%0d_bresp", i), 64'(bresp), 64'd0);
      end
      chk($sformatf("vec%0d_same_cycle_valid", i), 64'(early), 64'd0);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd1);
      chk($sformatf("vec%0d_m_addr", i), 64'(maddr), 64'(vec[i].addr));
      chk($sformatf("vec%0d_grant_after", i), 64'(grant), 64'd0);
      chk($sformatf("vec%0d_len_err", i), 64'(len_err), 64'd0);
    end

    // Simultaneous I/D reads: D first in both builds on the first conflict.
    order.delete();
    fork
      do_rd(0, 32'h000, 8'd0, lat, maddr, early, nb);
      do_rd(1, 32'h200, 8'd0, lat2, maddr2, early2, nb2);
    join
    chk("pair1_count", 64'(order.size()), 64'd2);
    chk("pair1_first", 64'(order.size() > 0 ? order[0] : -1), 64'd1);
    chk("pair1_second", 64'(order.size() > 1 ? order[1] : -1), 64'd0);
    chk("pair1_i_data", 64'(rbuf[0][0]), 64'hA000_0000);
    chk("pair1_d_data", 64'(rbuf[1][0]), 64'hA000_0080);

    order.delete();
    fork
      do_rd(0, 32'h004, 8'd0, lat, maddr, early, nb);
      do_rd(1, 32'h204, 8'd0, lat2, maddr2, early2, nb2);
    join
`ifdef ARB_RR_EN
    chk("pair2_first", 64'(order.size() > 0 ? order[0] : -1), 64'd0);
    chk("pair2_second", 64'(order.size() > 1 ? order[1] : -1), 64'd1);
`else
    chk("pair2_first", 64'(order.size() > 0 ? order[0] : -1), 64'd1);
    chk("pair2_second", 64'(order.size() > 1 ? order[1] : -1), 64'd0);
`endif
    chk("pair2_i_data", 64'(rbuf[0][0]), 64'hA000_0001);
    chk("pair2_d_data", 64'(rbuf[1][0]), 64'hA000_0081);

    // D raises AR and AW to the same address together: the write must win.
    order.delete();
    fork
      do_rd(1, 32'h080, 8'd0, lat, maddr, early, nb);
      do_wr(1, 32'h080, 8'd0, 32'h1234_5678, lat2, maddr2, early2, bresp);
    join
    chk("wfirst_first", 64'(order.size() > 0 ? order[0] : -1), 64'd3);
    chk("wfirst_second", 64'(order.size() > 1 ? order[1] : -1), 64'd1);
    chk("wfirst_rdata", 64'(rbuf[1][0]), 64'h1234_5678);
    chk("wfirst_bresp", 64'(bresp), 64'd0);

    // ARLEN=3 but slave ends the burst after 3 beats.
    short_last = 1'b1;
    do_rd(0, 32'h300, 8'd3, lat, maddr, early, nb);
    short_last = 1'b0;
    chk("short_beats", 64'(nb), 64'd3);
    chk("short_len_err", 64'(len_err), 64'd1);
    do_rd(1, 32'h304, 8'd0, lat, maddr, early, nb);
    chk("short_after_rdata", 64'(rbuf[1][0]), 64'hA000_00C1);
    chk("len_err_sticky", 64'(len_err), 64'd1);

    // Reset pulsed in the middle of an I burst.
    @(negedge clk);
    araddr[0] = 32'h300; arlen[0] = 8'd3; arvalid[0] = 1'b1; rready[0] = 1'b1;
    cyc = 0;
    while (!rvalid_s[0] && cyc < TMO) begin
      @(negedge clk); cyc++;
    end
    chk("midrst_burst_started", 64'(rvalid_s[0]), 64'd1);
    chk("midrst_grant_before", 64'(grant), 64'd1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst_outputs", 64'(any_out), 64'd0);
    chk("midrst_grant", 64'(grant), 64'd0);
    chk("midrst_len_err", 64'(len_err), 64'd0);
    arvalid[0] = 1'b0; rready[0] = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("postrst_outputs", 64'(any_out), 64'd0);
    chk("postrst_grant", 64'(grant), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
